// File: rtl/eth_phy_10g_pkg.sv
// Shared constants for the 10GBASE-R PHY: sync headers, scrambler and PRBS31 polynomials.
package eth_phy_10g_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int          SCR_WIDTH = 58;
    localparam logic [57:0] SCR_POLY  = 58'h8000000001;

    localparam int          PRBS31_WIDTH = 31;
    localparam logic [30:0] PRBS31_POLY  = 31'h10000001;
    localparam logic [30:0] PRBS31_SEED  = 31'h7fffffff;

endpackage

// File: rtl/lfsr.sv
// Combinational multi-bit Fibonacci LFSR step, LSB first in time; POLY bit k taps state[k-1].
// FEED_FORWARD=0 shifts the output bit back into the state (scrambler/generator), 1 shifts the input.
module lfsr #(
    parameter int                    LFSR_WIDTH   = 58,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = '0,
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    FEED_FORWARD = 0
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LFSR_WIDTH-1:0] state_out
);

    logic [LFSR_WIDTH-1:0] sv;
    logic                  fb;

    always_comb begin
        sv       = state_in;
        fb       = 1'b0;
        data_out = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            fb = sv[LFSR_WIDTH-1];
            for (int k = 1; k < LFSR_WIDTH; k++)
                if (LFSR_POLY[k]) fb = fb ^ sv[k-1];
            fb          = fb ^ data_in[i];
            data_out[i] = fb;
            sv          = {sv[LFSR_WIDTH-2:0], (FEED_FORWARD != 0) ? data_in[i] : fb};
        end
        state_out = sv;
    end

endmodule

// File: rtl/eth_phy_10g_tx_if.sv
// 10GBASE-R TX SERDES interface: x^58+x^39+1 scrambler, bad-header check, optional bit reverse/pipeline.
// Define ETH_PHY_10G_TX_PRBS31_EN to build the PRBS31 test-pattern generator.
module eth_phy_10g_tx_if
    import eth_phy_10g_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int HDR_WIDTH         = 2,
    parameter int BIT_REVERSE       = 0,
    parameter int SCRAMBLER_DISABLE = 0,
    parameter int SERDES_PIPELINE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] encoded_tx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    output logic [DATA_WIDTH-1:0] serdes_tx_data,
    output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
    input  logic                  tx_prbs31_enable,
    output logic                  tx_bad_hdr,
    output logic [7:0]            tx_bad_hdr_count,
    input  logic                  tx_bad_hdr_clear
);

    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $fatal(1, "eth_phy_10g_tx_if: DATA_WIDTH must be 64");
    end
    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $fatal(1, "eth_phy_10g_tx_if: HDR_WIDTH must be 2");
    end
    if (SERDES_PIPELINE < 0 || SERDES_PIPELINE > 4) begin : g_bad_pipeline
        $fatal(1, "eth_phy_10g_tx_if: SERDES_PIPELINE must be 0..4");
    end

    logic [SCR_WIDTH-1:0]  scr_state, scr_state_next;
    logic [DATA_WIDTH-1:0] scr_data;
    logic                  prbs_mode;

    lfsr #(
        .LFSR_WIDTH  (SCR_WIDTH),
        .LFSR_POLY   (SCR_POLY),
        .DATA_WIDTH  (DATA_WIDTH),
        .FEED_FORWARD(0)
    ) u_scrambler (
        .data_in  (encoded_tx_data),
        .state_in (scr_state),
        .data_out (scr_data),
        .state_out(scr_state_next)
    );

    // Keeps advancing in PRBS mode and when scrambling is disabled so the RX side stays in step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scr_state <= '1;
        else        scr_state <= scr_state_next;
    end

`ifdef ETH_PHY_10G_TX_PRBS31_EN
    logic [PRBS31_WIDTH-1:0]         prbs_state, prbs_state_next;
    logic [DATA_WIDTH+HDR_WIDTH-1:0] prbs_data;

    lfsr #(
        .LFSR_WIDTH  (PRBS31_WIDTH),
        .LFSR_POLY   (PRBS31_POLY),
        .DATA_WIDTH  (DATA_WIDTH + HDR_WIDTH),
        .FEED_FORWARD(0)
    ) u_prbs31 (
        .data_in  ('0),
        .state_in (prbs_state),
        .data_out (prbs_data),
        .state_out(prbs_state_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         prbs_state <= PRBS31_SEED;
        else if (prbs_mode) prbs_state <= prbs_state_next;
    end

    assign prbs_mode = tx_prbs31_enable;
`else
    logic unused_prbs31_enable;
    assign unused_prbs31_enable = tx_prbs31_enable;
    assign prbs_mode = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] sel_data, out_data;
    logic [HDR_WIDTH-1:0]  sel_hdr, out_hdr;

    always_comb begin
        sel_data = (SCRAMBLER_DISABLE != 0) ? encoded_tx_data : scr_data;
        sel_hdr  = encoded_tx_hdr;
`ifdef ETH_PHY_10G_TX_PRBS31_EN
        // Header bits leave first, so they sit in the low end of the generator word.
        if (prbs_mode) {sel_data, sel_hdr} = ~prbs_data;
`endif
        out_data = sel_data;
        out_hdr  = sel_hdr;
        if (BIT_REVERSE != 0) begin
            for (int i = 0; i < DATA_WIDTH; i++) out_data[i] = sel_data[DATA_WIDTH-1-i];
            for (int i = 0; i < HDR_WIDTH; i++)  out_hdr[i]  = sel_hdr[HDR_WIDTH-1-i];
        end
    end

    // Stage 0 is the mandatory output register; stages 1..SERDES_PIPELINE follow it.
    logic [DATA_WIDTH-1:0] pipe_data [0:SERDES_PIPELINE];
    logic [HDR_WIDTH-1:0]  pipe_hdr  [0:SERDES_PIPELINE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g <= SERDES_PIPELINE; g++) begin
                pipe_data[g] <= '0;
                pipe_hdr[g]  <= '0;
            end
        end else begin
            pipe_data[0] <= out_data;
            pipe_hdr[0]  <= out_hdr;
            for (int g = 1; g <= SERDES_PIPELINE; g++) begin
                pipe_data[g] <= pipe_data[g-1];
                pipe_hdr[g]  <= pipe_hdr[g-1];
            end
        end
    end

    assign serdes_tx_data = pipe_data[SERDES_PIPELINE];
    assign serdes_tx_hdr  = pipe_hdr[SERDES_PIPELINE];

    logic hdr_bad;
    assign hdr_bad = (encoded_tx_hdr != SYNC_DATA) && (encoded_tx_hdr != SYNC_CTRL) && !prbs_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_bad_hdr       <= 1'b0;
            tx_bad_hdr_count <= '0;
        end else begin
            tx_bad_hdr <= hdr_bad;
            if (tx_bad_hdr_clear)
                tx_bad_hdr_count <= hdr_bad ? 8'd1 : 8'd0;
            else if (hdr_bad && tx_bad_hdr_count != 8'hff)
                tx_bad_hdr_count <= tx_bad_hdr_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_eth_phy_10g_tx_if.sv
// Bench for eth_phy_10g_tx_if: four parameterisations share one stimulus stream and a bit-stream model.
module tb_eth_phy_10g_tx_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] enc_data = '0;
    logic [1:0]  enc_hdr = 2'b01;
    logic        prbs_en = 1'b0;
    logic        clr = 1'b0;

    logic [63:0] d_out [4];
    logic [1:0]  h_out [4];
    logic        bad   [4];
    logic [7:0]  cnt   [4];

    int cfg_sd [4] = '{0, 1, 1, 1};
    int cfg_br [4] = '{0, 0, 1, 0};
    int cfg_p  [4] = '{0, 3, 0, 0};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eth_phy_10g_tx_if u_dut0 (
        .clk(clk), .rst_n(rst_n), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
        .serdes_tx_data(d_out[0]), .serdes_tx_hdr(h_out[0]), .tx_prbs31_enable(prbs_en),
        .tx_bad_hdr(bad[0]), .tx_bad_hdr_count(cnt[0]), .tx_bad_hdr_clear(clr));

    eth_phy_10g_tx_if #(.SCRAMBLER_DISABLE(1), .SERDES_PIPELINE(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
        .serdes_tx_data(d_out[1]), .serdes_tx_hdr(h_out[1]), .tx_prbs31_enable(prbs_en),
        .tx_bad_hdr(bad[1]), .tx_bad_hdr_count(cnt[1]), .tx_bad_hdr_clear(clr));

    eth_phy_10g_tx_if #(.SCRAMBLER_DISABLE(1), .BIT_REVERSE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
        .serdes_tx_data(d_out[2]), .serdes_tx_hdr(h_out[2]), .tx_prbs31_enable(prbs_en),
        .tx_bad_hdr(bad[2]), .tx_bad_hdr_count(cnt[2]), .tx_bad_hdr_clear(clr));

    eth_phy_10g_tx_if #(.SCRAMBLER_DISABLE(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
        .serdes_tx_data(d_out[3]), .serdes_tx_hdr(h_out[3]), .tx_prbs31_enable(prbs_en),
        .tx_bad_hdr(bad[3]), .tx_bad_hdr_count(cnt[3]), .tx_bad_hdr_clear(clr));

    // Model: the scrambled stream obeys out[n] = in[n] ^ out[n-39] ^ out[n-58]; PRBS31 obeys
    // p[n] = p[n-31] ^ p[n-28]. Both histories start as all ones. Outputs are delay lines.
    bit          scr_hist [$];
    bit          prbs_hist [$];
    logic [63:0] md [4][5];
    logic [1:0]  mh [4][5];
    logic        m_bad;
    logic [7:0]  m_cnt;

    task automatic model_reset();
        scr_hist  = {};
        prbs_hist = {};
        for (int i = 0; i < 58; i++) scr_hist.push_back(1'b1);
        for (int i = 0; i < 31; i++) prbs_hist.push_back(1'b1);
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 5; s++) begin
                md[c][s] = '0;
                mh[c][s] = '0;
            end
        m_bad = 1'b0;
        m_cnt = '0;
    endtask

    task automatic model_step();
        logic [63:0] scr, d, rd;
        logic [1:0]  h, rh;
        logic [65:0] pw;
        logic        prbs_on, is_bad;
        bit          o;
`ifdef ETH_PHY_10G_TX_PRBS31_EN
        prbs_on = prbs_en;
`else
        prbs_on = 1'b0;
`endif
        for (int i = 0; i < 64; i++) begin
            o = enc_data[i] ^ scr_hist[scr_hist.size()-39] ^ scr_hist[scr_hist.size()-58];
            scr_hist.push_back(o);
            scr[i] = o;
        end
        while (scr_hist.size() > 58) void'(scr_hist.pop_front());
        pw = '0;
        if (prbs_on) begin
            for (int i = 0; i < 66; i++) begin
                o = prbs_hist[prbs_hist.size()-31] ^ prbs_hist[prbs_hist.size()-28];
                prbs_hist.push_back(o);
                pw[i] = o;
            end
            while (prbs_hist.size() > 31) void'(prbs_hist.pop_front());
        end
        for (int c = 0; c < 4; c++) begin
            d = (cfg_sd[c] != 0) ? enc_data : scr;
            h = enc_hdr;
            if (prbs_on) begin
                h = ~pw[1:0];
                d = ~pw[65:2];
            end
            rd = d;
            rh = h;
            if (cfg_br[c] != 0) begin
                for (int i = 0; i < 64; i++) rd[i] = d[63-i];
                rh = {h[0], h[1]};
            end
            for (int s = 4; s > 0; s--) begin
                md[c][s] = md[c][s-1];
                mh[c][s] = mh[c][s-1];
            end
            md[c][0] = rd;
            mh[c][0] = rh;
        end
        is_bad = (enc_hdr == 2'b00 || enc_hdr == 2'b11) && !prbs_on;
        m_bad  = is_bad;
        if (clr)                        m_cnt = is_bad ? 8'd1 : 8'd0;
        else if (is_bad && m_cnt < 255) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("data[%0d]", c), d_out[c], md[c][cfg_p[c]]);
            chk($sformatf("hdr[%0d]", c), {62'b0, h_out[c]}, {62'b0, mh[c][cfg_p[c]]});
            chk($sformatf("bad[%0d]", c), {63'b0, bad[c]}, {63'b0, m_bad});
            chk($sformatf("cnt[%0d]", c), {56'b0, cnt[c]}, {56'b0, m_cnt});
        end
    endtask

    // Inputs change on the falling edge; the DUT captures them on the next rising edge.
    task automatic tick(input logic r, input logic [63:0] d, input logic [1:0] h,
                        input logic p, input logic c);
        rst_n    = r;
        enc_data = d;
        enc_hdr  = h;
        prbs_en  = p;
        clr      = c;
        if (!r) model_reset();
        else    model_step();
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [1:0] rnd_hdr();
        if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
        return ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
    endfunction

    localparam logic [63:0] PATTERN = 64'h0123456789ABCDEF;

    initial begin
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            tick(1'b0, rnd64(), 2'($urandom()), 1'($urandom()), 1'($urandom()));
        chk("reset_data", d_out[0], 64'h0);
        chk("reset_cnt", {56'b0, cnt[0]}, 64'h0);

        // All-ones start state: bits 39..57 of a zero block come out set.
        tick(1'b1, 64'h0, 2'b01, 1'b0, 1'b0);
        chk("first_scrambled", d_out[0], 64'h03FF_FF80_0000_0000);
        chk("first_hdr", {62'b0, h_out[0]}, 64'h1);

        tick(1'b1, PATTERN, 2'b01, 1'b0, 1'b0);
        chk("bypass_p0", d_out[3], PATTERN);
        for (int i = 0; i < 3; i++) tick(1'b1, rnd64(), 2'b10, 1'b0, 1'b0);
        chk("bypass_p3", d_out[1], PATTERN);
        chk("bypass_p3_hdr", {62'b0, h_out[1]}, 64'h1);

        tick(1'b1, 64'h1, 2'b01, 1'b0, 1'b0);
        chk("bitrev_data", d_out[2], 64'h8000_0000_0000_0000);
        chk("bitrev_hdr", {62'b0, h_out[2]}, 64'h2);

        for (int i = 0; i < 1000; i++)
            tick(($urandom_range(0, 199) != 0), rnd64(), rnd_hdr(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));

        tick(1'b1, rnd64(), 2'b01, 1'b0, 1'b1);
        chk("clear_alone", {56'b0, cnt[0]}, 64'h0);
        tick(1'b1, rnd64(), 2'b00, 1'b0, 1'b0);
        chk("bad_00", {63'b0, bad[0]}, 64'h1);
        tick(1'b1, rnd64(), 2'b11, 1'b0, 1'b0);
        chk("bad_11", {63'b0, bad[0]}, 64'h1);
        chk("count_2", {56'b0, cnt[0]}, 64'h2);
        for (int i = 0; i < 300; i++) tick(1'b1, rnd64(), 2'($urandom_range(0, 1) * 3), 1'b0, 1'b0);
        chk("count_sat", {56'b0, cnt[0]}, 64'hff);
        tick(1'b1, rnd64(), 2'b00, 1'b0, 1'b1);
        chk("clear_with_bad", {56'b0, cnt[0]}, 64'h1);
        tick(1'b1, rnd64(), 2'b10, 1'b0, 1'b0);
        chk("bad_cleared", {63'b0, bad[0]}, 64'h0);
        tick(1'b1, rnd64(), 2'b01, 1'b0, 1'b1);
        chk("clear_again", {56'b0, cnt[0]}, 64'h0);

        for (int i = 0; i < 200; i++)
            tick(1'b1, rnd64(), rnd_hdr(), ($urandom_range(0, 1) != 0), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
